// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared constants for the UART transmit frame sequencer:
//   - FSM state encodings (3-bit, legacy-compatible numbering IDLE=0 .. STOP=4)
//   - MUX_SEL codes naming the current source of the serial bit
//   - line-level constants for the idle and start levels of the TX line
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_PAR   = 2'd2;
  localparam logic [1:0] SEL_STOP  = 2'd3;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_par_gen.sv
// -----------------------------------------------------------------------------
// uart_tx_par_gen
// Combinational parity generator for the latched transmit word.
// Ports:
//   DATA     in  WIDTH  latched data word
//   PAR_TYP  in  1      0 = even parity, 1 = odd parity
//   PAR_BIT  out 1      parity bit to place on the line
// -----------------------------------------------------------------------------
module uart_tx_par_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] DATA,
  input  logic             PAR_TYP,
  output logic             PAR_BIT
);

  // Even parity is the XOR of all bits; odd parity is its complement.
  assign PAR_BIT = (^DATA) ^ PAR_TYP;

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit frame sequencer. CLK is the bit clock: one serial bit per cycle.
// A word is accepted on a rising edge with DATA_VALID=1 while idle (or on the
// final stop cycle, for back-to-back frames) and is sent as:
//   start(0), data LSB first, optional parity, stop(1).
// Configuration macro: UART_TX_TWO_STOP_EN -- when defined the stop bit lasts
// two cycles and back-to-back acceptance happens on the second stop cycle.
// Ports:
//   CLK        in  1      TX bit clock
//   RST        in  1      asynchronous active-high reset
//   P_DATA     in  WIDTH  parallel data to send
//   DATA_VALID in  1      P_DATA valid (single-cycle or held)
//   PAR_EN     in  1      1 = insert parity bit
//   PAR_TYP    in  1      0 = even, 1 = odd
//   TX_OUT     out 1      serial line, idle high
//   BUSY       out 1      frame in progress
//   MUX_SEL    out 2      current bit source (0 start,1 data,2 parity,3 stop/idle)
// Handshake: DATA_VALID acts as valid; the implied ready is "idle or on the last
// stop cycle". A word is taken only on an edge where both hold; otherwise
// DATA_VALID is ignored and the upstream must hold it or retry.
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             BUSY,
  output logic [1:0]       MUX_SEL
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] data_q;
  logic             par_en_q;
  logic             par_typ_q;
  logic             par_bit;
  logic             stop_last;
  logic             accept;

  uart_tx_par_gen #(.WIDTH(WIDTH)) u_par_gen (
    .DATA    (data_q),
    .PAR_TYP (par_typ_q),
    .PAR_BIT (par_bit)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt;
  assign stop_last = stop_cnt;
`else
  assign stop_last = 1'b1;
`endif

  assign cnt_nxt = cnt + 1'b1;

  // Ready condition: idle, or the final stop cycle (back-to-back frames).
  assign accept = DATA_VALID &&
                  ((state == ST_IDLE) || ((state == ST_STOP) && stop_last));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= IDLE_BIT;
      BUSY      <= 1'b0;
      MUX_SEL   <= SEL_STOP;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt  <= 1'b0;
`endif
    end else if (accept) begin
      // Inputs are captured here so later changes cannot disturb the frame.
      state     <= ST_START;
      cnt       <= '0;
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      TX_OUT    <= START_BIT;
      BUSY      <= 1'b1;
      MUX_SEL   <= SEL_START;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          TX_OUT  <= IDLE_BIT;
          BUSY    <= 1'b0;
          MUX_SEL <= SEL_STOP;
        end
        ST_START: begin
          state   <= ST_DATA;
          cnt     <= '0;
          TX_OUT  <= data_q[0];
          MUX_SEL <= SEL_DATA;
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            // The cycle just finished carried the last data bit.
            cnt <= '0;
            if (par_en_q) begin
              state   <= ST_PARITY;
              TX_OUT  <= par_bit;
              MUX_SEL <= SEL_PAR;
            end else begin
              state   <= ST_STOP;
              TX_OUT  <= IDLE_BIT;
              MUX_SEL <= SEL_STOP;
            end
          end else begin
            cnt    <= cnt_nxt;
            TX_OUT <= data_q[cnt_nxt];
          end
        end
        ST_PARITY: begin
          state   <= ST_STOP;
          TX_OUT  <= IDLE_BIT;
          MUX_SEL <= SEL_STOP;
        end
        ST_STOP: begin
          if (stop_last) begin
            state   <= ST_IDLE;
            TX_OUT  <= IDLE_BIT;
            BUSY    <= 1'b0;
            MUX_SEL <= SEL_STOP;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= 1'b0;
`endif
          end else begin
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= 1'b1;
`endif
            TX_OUT <= IDLE_BIT;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          TX_OUT  <= IDLE_BIT;
          BUSY    <= 1'b0;
          MUX_SEL <= SEL_STOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl. Expected line states {TX_OUT,BUSY,MUX_SEL}
// are pushed into exp_q as each word is offered, and popped one per clock.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         tx_out;
  logic         busy;
  logic [1:0]   mux_sel;

  logic [3:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  uart_tx_ctrl #(.WIDTH(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .TX_OUT     (tx_out),
    .BUSY       (busy),
    .MUX_SEL    (mux_sel)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected-frame model: start, LSB-first data, optional parity, stop bit(s).
  task automatic push_frame(input logic [W-1:0] d, input logic pen, input logic ptyp);
    logic pbit;
    exp_q.push_back({1'b0, 1'b1, 2'd0});
    for (int i = 0; i < W; i++) exp_q.push_back({d[i], 1'b1, 2'd1});
    pbit = ptyp ? ~(^d) : (^d);
    if (pen) exp_q.push_back({pbit, 1'b1, 2'd2});
    exp_q.push_back({1'b1, 1'b1, 2'd3});
`ifdef UART_TX_TWO_STOP_EN
    exp_q.push_back({1'b1, 1'b1, 2'd3});
`endif
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b0, 2'd3});
  endtask

  function automatic int frame_len(input logic pen);
    int n;
    n = W + 2 + (pen ? 1 : 0);
`ifdef UART_TX_TWO_STOP_EN
    n = n + 1;
`endif
    return n;
  endfunction

  // One clock: sample #1 after the rising edge and compare with the queue head.
  task automatic step(input string tag);
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    @(posedge clk);
    #1;
    obs_v = {tx_out, busy, mux_sel};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %b but no expectation queued", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s: {tx,busy,sel} observed=%b expected=%b", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
  endtask

  // Offer a word for one cycle, then scramble inputs while the frame runs.
  task automatic send_one(input string tag, input logic [W-1:0] d,
                          input logic pen, input logic ptyp);
    p_data = d; par_en = pen; par_typ = ptyp; data_valid = 1'b1;
    push_frame(d, pen, ptyp);
    push_idle(1);
    step(tag);
    data_valid = 1'b0;
    p_data = ~d; par_en = ~pen; par_typ = ~ptyp;
    drain(tag);
  endtask

  task automatic check_direct(input string tag, input logic [3:0] exp_v);
    checks++;
    assert ({tx_out, busy, mux_sel} === exp_v) else begin
      errors++;
      $error("FAIL %s: {tx,busy,sel} observed=%b expected=%b", tag,
             {tx_out, busy, mux_sel}, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    #3;
    check_direct("reset_state", {1'b1, 1'b0, 2'd3});
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    push_idle(2);
    drain("idle_after_reset");

    send_one("a5_even", 8'hA5, 1'b1, 1'b0);
    send_one("01_odd", 8'h01, 1'b1, 1'b1);
    send_one("03_odd", 8'h03, 1'b1, 1'b1);
    send_one("00_even", 8'h00, 1'b1, 1'b0);
    send_one("ff_nopar", 8'hFF, 1'b0, 1'b0);
    send_one("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));

    // Back-to-back: DATA_VALID held across the first frame's last stop cycle.
    p_data = 8'h55; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    push_frame(8'h55, 1'b1, 1'b0);
    push_frame(8'hAA, 1'b1, 1'b0);
    push_idle(1);
    step("b2b_first");
    p_data = 8'hAA;
    for (int i = 0; i < frame_len(1'b1); i++) step("b2b_first");
    data_valid = 1'b0;
    p_data = 8'h0F;
    drain("b2b_second");

    // Reset during data bit 4: outputs must return to idle without a clock edge.
    p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    push_frame(8'hA5, 1'b0, 1'b0);
    step("pre_reset");
    data_valid = 1'b0;
    for (int i = 0; i < 5; i++) step("pre_reset");
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    check_direct("async_reset", {1'b1, 1'b0, 2'd3});
    p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
    @(negedge clk);
    check_direct("reset_held", {1'b1, 1'b0, 2'd3});
    rst = 1'b0;
    push_frame(8'h3C, 1'b1, 1'b1);
    push_idle(1);
    step("post_reset");
    data_valid = 1'b0;
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Accepts a parallel byte with a valid strobe, then sequences start bit, LSB-first data, optional parity bit and stop bit onto the serial line.
- Sits between the register file / host FIFO and the TX pin.
- CLK is the TX bit clock: one serial bit per CLK cycle.

Parameters:
- WIDTH, 8, data word width in bits (≥2).

Ports:
- CLK  input  1  TX bit clock.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  WIDTH  parallel data to send.
- DATA_VALID  input  1  P_DATA valid; single-cycle or held.
- PAR_EN  input  1  1 = parity bit inserted.
- PAR_TYP  input  1  0 = even, 1 = odd.
- TX_OUT  output  1  serial line; idle high.
- BUSY  output  1  frame in progress.
- MUX_SEL  output  2  current bit source: 0 = start, 1 = data, 2 = parity, 3 = stop/idle. For debug and external mux reuse.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - state IDLE, TX_OUT=1, BUSY=0, MUX_SEL=3, bit counter 0, data latch 0.
- All outputs are registered; TX_OUT carries the bit of the state just entered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - Occurs on a rising edge in IDLE with DATA_VALID=1.
  - Latches P_DATA, PAR_EN, PAR_TYP.
  - Enters START: TX_OUT=0, BUSY=1, MUX_SEL=0.
  - Changes to inputs after acceptance do not affect the frame.
- START → DATA after 1 cycle. TX_OUT=latched[0], counter=0.
- DATA:
  - Each cycle, counter increments and TX_OUT=latched[counter].
  - After the cycle carrying bit WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
  - Counter width $clog2(WIDTH); it resets to 0 on leaving DATA (no wrap-around exposure).
- PARITY, 1 cycle:
  - TX_OUT = ^latched when PAR_TYP=0.
  - TX_OUT = ~^latched when PAR_TYP=1.
- STOP, 1 cycle, TX_OUT=1:
  - On the final stop cycle's edge with DATA_VALID=1: accept a new word and go directly to START (back-to-back, no idle gap; BUSY stays 1).
  - Otherwise go to IDLE; BUSY=0.
- DATA_VALID is ignored in START, DATA and PARITY. There is no queuing; the upstream must hold DATA_VALID or retry.
- Frame length in cycles = WIDTH + 2 + PAR_EN (+1 with the optional feature).
- Latency: DATA_VALID edge → start bit on TX_OUT at the same accepting edge (0 extra cycles).
- BUSY is high for exactly the frame length.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - STOP lasts 2 cycles, using a 1-bit stop counter.
  - Back-to-back acceptance is checked only on the second stop cycle.
  - Frame length increases by 1.
- Undefined: single stop bit; no stop-counter logic is present.

Decomposition:
- Package uart_tx_pkg:
  - state encoding localparams (IDLE=0 … STOP=4, 3-bit);
  - MUX_SEL codes (SEL_START, SEL_DATA, SEL_PAR, SEL_STOP);
  - line-level constants (IDLE_BIT=1, START_BIT=0).
- Natural sub-module: uart_tx_par_gen, a combinational parity generator fed by the latched word and the latched PAR_TYP.
- FSM, counter and output register stay in uart_tx_ctrl.

Test Plan:
- WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. BUSY high 11 cycles, then TX_OUT=1, BUSY=0.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=1 → parity bit 0. P_DATA=0x03, PAR_TYP=1 → parity bit 1. P_DATA=0x00, PAR_TYP=0 → parity bit 0.
- PAR_EN=0, P_DATA=0xFF → 0, eight 1s, 1 (10 cycles). MUX_SEL never equals 2.
- DATA_VALID held high with 0x55 then 0xAA → second start bit immediately follows the first stop bit. No idle cycle; BUSY continuously 1. Changing P_DATA mid-frame does not corrupt the first frame.
- Assert RST during data bit 4 → TX_OUT=1, BUSY=0, MUX_SEL=3 without waiting for CLK. After release with DATA_VALID=1, a full clean frame is sent.
- With UART_TX_TWO_STOP_EN defined, 0xA5, PAR_EN=1 → frame of 12 cycles ending in 1,1. Back-to-back acceptance occurs only on the second stop cycle.
